// File: rtl/divider10_arbiter_pkg.sv
// Shared constants and state encoding for the divider10 arbiter.
package divider10_arbiter_pkg;

  localparam int DIV_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Quotient reported for a zero divisor; the remainder reports the dividend.
  localparam logic [DIV_W-1:0] DIV0_QUOT = 10'h3FF;

endpackage

// File: rtl/divider10.sv
// 10-bit restoring divider, one quotient bit per cycle, not pipelined.
// start loads operands; ready rises ten cycles later and stays high until the
// next start. No reset: every start fully reloads the datapath.
module divider10
  import divider10_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divider,
  output logic             ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvs;
  logic [3:0]       cnt;
  logic             rdy;
  logic [DIV_W:0]   trial;
  logic [DIV_W-1:0] diff;
  logic             ge;

  // Trial subtraction for the current quotient bit. When trial >= divisor the
  // true difference is below the divisor, so the low DIV_W bits are exact.
  always_comb begin
    trial = {rem, quo[DIV_W-1]};
    diff  = trial[DIV_W-1:0] - dvs;
    ge    = (trial >= {1'b0, dvs});
  end

  // Load on start, then shift/subtract until the count runs out.
  always_ff @(posedge clk) begin
    if (start) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divider;
      cnt <= 4'(DIV_W);
      rdy <= 1'b0;
    end else if (cnt != 4'd0) begin
      quo <= {quo[DIV_W-2:0], ge};
      rem <= ge ? diff : trial[DIV_W-1:0];
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) rdy <= 1'b1;
    end
  end

  assign ready     = rdy;
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/divider10_arbiter.sv
// Round-robin arbiter sharing one divider10 among NREQ requesters.
// Zero divisors bypass the divider and complete the cycle after ack.
//
// state  | meaning
// IDLE   | no request owns the divider; grants happen here
// RUN    | divider counting for the latched grant
// FINISH | result captured, done pulse for the latched grant
module divider10_arbiter
  import divider10_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [DIV_W*NREQ-1:0] dividend,
  input  logic [DIV_W*NREQ-1:0] divider,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [DIV_W-1:0]      quotient,
  output logic [DIV_W-1:0]      remainder,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt;
  logic [PW-1:0]    pick;
  logic             found;
  logic [NREQ-1:0]  req_m;
  logic [DIV_W-1:0] sel_n;
  logic [DIV_W-1:0] sel_d;
  logic             grant;
  logic             bypass;
  logic             div_start;
  logic             div_ready;
  logic             run_first;
  logic             capture;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_r;

  // Rotating priority pick from ptr. A requester whose bypass done is showing
  // this cycle is masked so ack and done never coincide for the same index.
  always_comb begin
    int idx;
    idx   = 0;
    req_m = req & ~done;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req_m[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign sel_n   = dividend[int'(pick)*DIV_W +: DIV_W];
  assign sel_d   = divider[int'(pick)*DIV_W +: DIV_W];
  assign bypass  = (sel_d == '0);
  assign grant   = (state == IDLE) && found && !rst;
  // ready is stale in the cycle right after start, hence run_first.
  assign capture = (state == RUN) && div_ready && !run_first;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant && !bypass) state_nxt = RUN;
      RUN:     if (capture) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant-cycle outputs and busy flag.
  always_comb begin
    ack       = '0;
    div_start = 1'b0;
    if (grant) begin
      ack[pick] = 1'b1;
      div_start = !bypass;
    end
    busy = (state == RUN) || (state == FINISH);
  end

  // Pointer, latched grant, result registers and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      gnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= '0;
      run_first <= 1'b0;
    end else begin
      done      <= '0;
      run_first <= 1'b0;
      if (grant) begin
        gnt <= pick;
        ptr <= (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
        if (bypass) begin
          quotient  <= DIV0_QUOT;
          remainder <= sel_n;
          done      <= NREQ'(1) << pick;
        end else begin
          run_first <= 1'b1;
        end
      end
      if (capture) begin
        quotient  <= div_q;
        remainder <= div_r;
        done      <= NREQ'(1) << gnt;
      end
    end
  end

  divider10 u_div (
    .clk       (clk),
    .start     (div_start),
    .dividend  (sel_n),
    .divider   (sel_d),
    .ready     (div_ready),
    .quotient  (div_q),
    .remainder (div_r)
  );

endmodule
